// File: rtl/grf_wport_arb.sv
// Write-port arbiter for the register file: the W-stage primary always wins, and
// secondary writes wait in a 2-entry in-order buffer that can forward and can be squashed.
module grf_wport_arb #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_RegWrite,
  input  logic [4:0]  W_A3,
  input  logic [31:0] W_RegWriteData,
  input  logic        S_valid,
  output logic        S_ready,
  input  logic [4:0]  S_A3,
  input  logic [31:0] S_WD,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  output logic        fwd_hit1,
  output logic [31:0] fwd_val1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_val2,
  output logic        GRF_WE,
  output logic [4:0]  GRF_A3,
  output logic [31:0] GRF_WD,
  output logic        stall_req
);

  logic [1:0]  cnt, cnt_next, s_cnt;
  logic [4:0]  a3_0, a3_1, a3_0_next, a3_1_next;
  logic [31:0] wd_0, wd_1, wd_0_next, wd_1_next;
  logic [3:0]  starve, starve_next;
  logic        prim, push, pop, keep0, keep1, sq_any;

  // Youngest match wins: slot 1 is only valid (and younger) when two entries are held.
  function automatic logic [32:0] lookup(input logic [4:0] a, input logic [1:0] n,
                                         input logic [4:0] k0, input logic [31:0] d0,
                                         input logic [4:0] k1, input logic [31:0] d1);
    lookup = '0;
    if (a != 5'd0) begin
      if (n == 2'd2 && k1 == a)
        lookup = {1'b1, d1};
      else if (n != 2'd0 && k0 == a)
        lookup = {1'b1, d0};
    end
  endfunction

  assign prim    = W_RegWrite && (W_A3 != 5'd0);
  assign S_ready = !reset && (cnt != 2'd2);
  assign push    = S_valid && S_ready && (S_A3 != 5'd0);
  assign pop     = !prim && (cnt != 2'd0);
  assign keep0   = (cnt != 2'd0) && !pop && !(prim && a3_0 == W_A3);
  assign keep1   = (cnt == 2'd2) && !(prim && a3_1 == W_A3);
  assign sq_any  = prim && (((cnt != 2'd0) && a3_0 == W_A3) || ((cnt == 2'd2) && a3_1 == W_A3));

  assign {fwd_hit1, fwd_val1} = reset ? 33'd0 : lookup(D_A1, cnt, a3_0, wd_0, a3_1, wd_1);
  assign {fwd_hit2, fwd_val2} = reset ? 33'd0 : lookup(D_A2, cnt, a3_0, wd_0, a3_1, wd_1);

  always_comb begin
    GRF_WE = 1'b0;
    GRF_A3 = 5'd0;
    GRF_WD = 32'd0;
    if (!reset) begin
      if (prim) begin
        GRF_WE = 1'b1;
        GRF_A3 = W_A3;
        GRF_WD = W_RegWriteData;
      end else if (cnt != 2'd0) begin
        GRF_WE = 1'b1;
        GRF_A3 = a3_0;
        GRF_WD = wd_0;
      end
    end
  end

  // Compact the surviving entries toward the head, then append any push behind them.
  always_comb begin
    s_cnt     = {1'b0, keep0} + {1'b0, keep1};
    a3_0_next = a3_0;
    wd_0_next = wd_0;
    a3_1_next = a3_1;
    wd_1_next = wd_1;
    if (!keep0 && keep1) begin
      a3_0_next = a3_1;
      wd_0_next = wd_1;
    end else if (!keep0 && push) begin
      a3_0_next = S_A3;
      wd_0_next = S_WD;
    end
    if (s_cnt == 2'd1 && push) begin
      a3_1_next = S_A3;
      wd_1_next = S_WD;
    end
    cnt_next = s_cnt + {1'b0, push};

    starve_next = starve;
    if ((cnt == 2'd0) || pop || (sq_any && cnt_next == 2'd0))
      starve_next = 4'd0;
    else if (prim && starve != 4'd15)
      starve_next = starve + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 2'd0;
      starve    <= 4'd0;
      stall_req <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      a3_0      <= a3_0_next;
      wd_0      <= wd_0_next;
      a3_1      <= a3_1_next;
      wd_1      <= wd_1_next;
      starve    <= starve_next;
      stall_req <= (starve_next >= 4'(STARVE_LIM));
    end
  end

endmodule

// File: tb/tb_grf_wport_arb.sv
// Bench for grf_wport_arb: cycle-by-cycle vector table with hand-derived expectations,
// plus a long starvation sequence that drives the counter into saturation.
module tb_grf_wport_arb;

  logic        clk, reset;
  logic        W_RegWrite, S_valid, S_ready;
  logic [4:0]  W_A3, S_A3, D_A1, D_A2, GRF_A3;
  logic [31:0] W_RegWriteData, S_WD, fwd_val1, fwd_val2, GRF_WD;
  logic        fwd_hit1, fwd_hit2, GRF_WE, stall_req;

  grf_wport_arb #(.STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .W_RegWrite(W_RegWrite), .W_A3(W_A3), .W_RegWriteData(W_RegWriteData),
    .S_valid(S_valid), .S_ready(S_ready), .S_A3(S_A3), .S_WD(S_WD),
    .D_A1(D_A1), .D_A2(D_A2),
    .fwd_hit1(fwd_hit1), .fwd_val1(fwd_val1), .fwd_hit2(fwd_hit2), .fwd_val2(fwd_val2),
    .GRF_WE(GRF_WE), .GRF_A3(GRF_A3), .GRF_WD(GRF_WD), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic wre; logic [4:0] wa3; logic [31:0] wwd;
    logic sv; logic [4:0] sa3; logic [31:0] swd;
    logic [4:0] da1; logic [4:0] da2;
    logic e_rdy; logic e_we; logic [4:0] e_a3; logic [31:0] e_wd;
    logic e_h1; logic [31:0] e_v1; logic e_h2; logic [31:0] e_v2; logic e_st;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(
      input logic rst, input logic wre, input logic [4:0] wa3, input logic [31:0] wwd,
      input logic sv, input logic [4:0] sa3, input logic [31:0] swd,
      input logic [4:0] da1, input logic [4:0] da2,
      input logic rdy, input logic we, input logic [4:0] a3, input logic [31:0] wd,
      input logic h1, input logic [31:0] v1, input logic h2, input logic [31:0] v2,
      input logic st);
    vec_t v;
    v.rst = rst; v.wre = wre; v.wa3 = wa3; v.wwd = wwd;
    v.sv = sv; v.sa3 = sa3; v.swd = swd; v.da1 = da1; v.da2 = da2;
    v.e_rdy = rdy; v.e_we = we; v.e_a3 = a3; v.e_wd = wd;
    v.e_h1 = h1; v.e_v1 = v1; v.e_h2 = h2; v.e_v2 = v2; v.e_st = st;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0,0,0,0, 0,0,0, 0,0, 1,0,0,0, 0,0,0,0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %0h expected %0h", n_vec, name, act, exp);
    end
  endtask

  task automatic sample();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL vec %0d scoreboard: got empty queue expected one entry", n_vec);
      return;
    end
    e = exp_q.pop_front();
    chk("S_ready",   {31'd0, S_ready},   {31'd0, e.e_rdy});
    chk("GRF_WE",    {31'd0, GRF_WE},    {31'd0, e.e_we});
    if (!e.rst) begin
      chk("GRF_A3",  {27'd0, GRF_A3},    {27'd0, e.e_a3});
      chk("GRF_WD",  GRF_WD,             e.e_wd);
    end
    chk("fwd_hit1",  {31'd0, fwd_hit1},  {31'd0, e.e_h1});
    chk("fwd_val1",  fwd_val1,           e.e_v1);
    chk("fwd_hit2",  {31'd0, fwd_hit2},  {31'd0, e.e_h2});
    chk("fwd_val2",  fwd_val2,           e.e_v2);
    chk("stall_req", {31'd0, stall_req}, {31'd0, e.e_st});
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst; W_RegWrite = v.wre; W_A3 = v.wa3; W_RegWriteData = v.wwd;
    S_valid = v.sv; S_A3 = v.sa3; S_WD = v.swd; D_A1 = v.da1; D_A2 = v.da2;
    exp_q.push_back(v);
    #2;
    sample();
    n_vec++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; W_RegWrite = 1'b0; W_A3 = '0; W_RegWriteData = '0;
    S_valid = 1'b0; S_A3 = '0; S_WD = '0; D_A1 = '0; D_A2 = '0;
    repeat (2) @(posedge clk);

    // reset with busy inputs: nothing gets through
    tbl.push_back(mk(1,1,3,'h55, 1,2,'h22, 2,0, 0,0,0,0, 0,0,0,0, 0));
    // idle primary: push, write one cycle later, then empty
    tbl.push_back(mk(0,0,0,0, 1,5,'h11, 5,0, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 5,5, 1,1,5,'h11, 1,'h11,1,'h11, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 5,0, 1,0,0,0, 0,0,0,0, 0));
    // fill under a busy primary, third request refused, drain in order
    tbl.push_back(mk(0,1,10,'hA0, 1,3,'h33, 3,0, 1,1,10,'hA0, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,11,'hB0, 1,4,'h44, 3,4, 1,1,11,'hB0, 1,'h33,0,0, 0));
    tbl.push_back(mk(0,1,12,'hC0, 1,6,'h66, 4,3, 0,1,12,'hC0, 1,'h44,1,'h33, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,1,3,'h33, 0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,1,4,'h44, 0,0,0,0, 0));
    tbl.push_back(idle());
    // squash of a buffered $7 by the primary
    tbl.push_back(mk(0,0,0,0, 1,7,'hAA, 0,0, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,7,'hBB, 0,0,0, 7,0, 1,1,7,'hBB, 1,'hAA,0,0, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 7,0, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(idle());
    // forwarding picks the youngest $9; both squashed by a primary $9
    tbl.push_back(mk(0,0,0,0, 1,9,'h1, 0,0, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,20,'h200, 1,9,'h2, 9,0, 1,1,20,'h200, 1,'h1,0,0, 0));
    tbl.push_back(mk(0,1,21,'h210, 0,0,0, 9,0, 0,1,21,'h210, 1,'h2,0,0, 0));
    tbl.push_back(mk(0,1,9,'h99, 1,9,'h3, 9,0, 0,1,9,'h99, 1,'h2,0,0, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 9,0, 1,0,0,0, 0,0,0,0, 0));
    // same-cycle push with A3 equal to the primary survives the squash
    tbl.push_back(mk(0,0,0,0, 1,8,'h80, 0,0, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,8,'h88, 1,8,'h81, 8,0, 1,1,8,'h88, 1,'h80,0,0, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 8,0, 1,1,8,'h81, 1,'h81,0,0, 0));
    tbl.push_back(idle());
    // $0 request accepted and dropped; primary to $0 is inactive
    tbl.push_back(mk(0,0,0,0, 1,0,'hDEAD, 0,0, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(idle());
    tbl.push_back(mk(0,1,0,'h77, 0,0,0, 0,0, 1,0,0,0, 0,0,0,0, 0));
    // starvation reaching the limit, then push+pop at count 1
    tbl.push_back(mk(0,0,0,0, 1,13,'hD1, 0,0, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,1,'h1001, 0,0,0, 0,0, 1,1,1,'h1001, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,2,'h1002, 0,0,0, 0,0, 1,1,2,'h1002, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,3,'h1003, 0,0,0, 0,0, 1,1,3,'h1003, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,4,'h1004, 0,0,0, 0,0, 1,1,4,'h1004, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,5,'h1005, 0,0,0, 13,0, 1,1,5,'h1005, 1,'hD1,0,0, 1));
    tbl.push_back(mk(0,0,0,0, 1,14,'hE1, 0,0, 1,1,13,'hD1, 0,0,0,0, 1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 14,13, 1,1,14,'hE1, 1,'hE1,0,0, 0));
    tbl.push_back(idle());
    // reset with two entries buffered
    tbl.push_back(mk(0,1,15,'hF0, 1,16,'h160, 0,0, 1,1,15,'hF0, 0,0,0,0, 0));
    tbl.push_back(mk(0,1,17,'h170, 1,18,'h180, 16,0, 1,1,17,'h170, 1,'h160,0,0, 0));
    tbl.push_back(mk(1,1,19,'h190, 1,20,'h200, 16,18, 0,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 16,18, 1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(idle());

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    // long starvation: counter saturates, stall stays high until the pop
    apply(mk(0,0,0,0, 1,22,'h220, 0,0, 1,0,0,0, 0,0,0,0, 0));
    for (int i = 0; i < 20; i++)
      apply(mk(0,1,23,32'(i), 0,0,0, 22,0, 1,1,23,32'(i), 1,'h220,0,0, (i >= 4)));
    apply(mk(0,0,0,0, 0,0,0, 22,0, 1,1,22,'h220, 1,'h220,0,0, 1));
    apply(mk(0,0,0,0, 0,0,0, 22,0, 1,0,0,0, 0,0,0,0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
